// File: rtl/led_blink_sched.sv
// led_blink_sched: round-robin sharing of one status LED between requesters, each showing a blink code
module led_blink_sched #(
  parameter int NREQ    = 4,
  parameter int BLINK_W = 4,
  parameter int CNT_W   = 8,
  parameter int ON_CYC  = 10,
  parameter int OFF_CYC = 10,
  parameter int GAP_CYC = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*BLINK_W-1:0] req_blinks,
  input  logic                    abort,
  output logic                    led,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    busy
);
  localparam int LW = $clog2(NREQ);
  localparam logic [CNT_W-1:0] ON_T  = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_T = CNT_W'(OFF_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_T = CNT_W'(GAP_CYC - 1);
  localparam logic [NREQ-1:0]  ONE   = NREQ'(1);
  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0]   tmr;
  logic [BLINK_W-1:0] rem, bl_w;
  logic [LW-1:0]      last, owner, win, cand;
  logic               found, grant, ph_end;
  assign busy = state != IDLE;
  // round-robin search starting just after the last winner
  always_comb begin
    found = 1'b0;
    win   = last;
    cand  = last;
    for (int k = 1; k <= NREQ; k++) begin
      cand = LW'((int'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end
  // phase sequencing: grant decision, phase-end detection and next state
  always_comb begin
    bl_w     = req_blinks[win*BLINK_W +: BLINK_W];
    grant    = state == IDLE && found && !abort;
    ph_end   = state == ON  ? tmr == ON_T :
               state == OFF ? tmr == OFF_T :
               state == GAP ? tmr == GAP_T : 1'b0;
    state_nx = abort         ? IDLE :
               state == IDLE ? (grant ? (bl_w != '0 ? ON : GAP) : IDLE) :
               !ph_end       ? state :
               state == ON   ? OFF :
               state == OFF  ? (rem != '0 ? ON : GAP) : IDLE;
  end
  // state, timer, blink count, ownership and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr   <= '0;
      rem   <= '0;
      last  <= LW'(NREQ - 1);
      owner <= '0;
      led   <= 1'b0;
      gnt   <= '0;
      done  <= '0;
    end else begin
      state <= state_nx;
      tmr   <= (state_nx != state || state == IDLE) ? '0 : tmr + 1'b1;
      led   <= state_nx == ON;
      gnt   <= grant ? ONE << win : '0;
      done  <= (state == GAP && ph_end && !abort) ? ONE << owner : '0;
      if (grant) begin
        rem   <= bl_w;
        owner <= win;
        last  <= win;
      end else if (state == ON && ph_end && !abort) begin
        rem <= rem - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_led_blink_sched.sv
// tb_led_blink_sched: directed vector table plus hand sequences for back-to-back, abort and reset cases
module tb_led_blink_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'hF;
  logic [15:0] req_blinks = 16'h0002;
  logic        abort = 1'b0;
  logic        led, busy;
  logic [3:0]  gnt, done;
  int          checks = 0;
  int          failures = 0;

  led_blink_sched #(.NREQ(4), .BLINK_W(4), .CNT_W(8), .ON_CYC(3), .OFF_CYC(2), .GAP_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_blinks(req_blinks), .abort(abort),
    .led(led), .gnt(gnt), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] blinks;
    logic        abort;
    logic        led;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
  } vec_t;
  vec_t tbl[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  int gi[4], gcy[4], dcy[4];
  int ng, nd, g;

  initial begin
    for (int i = 0; i < 24; i++) tbl[i] = '{1'b1, 4'h0, 16'h0002, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    tbl[0].rst_n = 1'b0; tbl[0].req = 4'hF;
    tbl[1].rst_n = 1'b0; tbl[1].req = 4'hF;
    tbl[2].req = 4'hF;
    for (int i = 3; i <= 16; i++) tbl[i].busy = 1'b1;
    for (int i = 3; i <= 5; i++) tbl[i].led = 1'b1;
    for (int i = 8; i <= 10; i++) tbl[i].led = 1'b1;
    tbl[3].gnt = 4'b0001;
    tbl[17].done = 4'b0001; tbl[17].req = 4'b1000;
    tbl[18].gnt = 4'b1000;
    for (int i = 18; i <= 21; i++) tbl[i].busy = 1'b1;
    tbl[22].done = 4'b1000;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_led", i), 32'(led), 32'(tbl[i].led));
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      rst_n = tbl[i].rst_n; req = tbl[i].req; req_blinks = tbl[i].blinks; abort = tbl[i].abort;
    end

    // back-to-back service of requesters 0 and 2, one blink each
    @(negedge clk);
    req = 4'b0101; req_blinks = 16'h0101;
    ng = 0; nd = 0;
    for (int c = 1; c < 200 && nd < 4; c++) begin
      @(negedge clk);
      if (gnt != 4'h0 && ng < 4) begin gi[ng] = oh(gnt); gcy[ng] = c; ng++; end
      if (done != 4'h0 && nd < 4) begin dcy[nd] = c; nd++; end
      if (ng == 4) req = 4'h0;
    end
    chk("t3_grants", 32'(ng), 32'd4);
    chk("t3_dones", 32'(nd), 32'd4);
    if (ng == 4 && nd == 4) begin
      chk("t3_g0", 32'(gi[0]), 32'd0);
      chk("t3_g1", 32'(gi[1]), 32'd2);
      chk("t3_g2", 32'(gi[2]), 32'd0);
      chk("t3_g3", 32'(gi[3]), 32'd2);
      chk("t3_len", 32'(dcy[0] - gcy[0]), 32'd9);
      for (int i = 1; i < 4; i++) chk($sformatf("t3_b2b%0d", i), 32'(gcy[i] - dcy[i-1]), 32'd1);
    end
    @(negedge clk);

    // abort during the second ON cycle of requester 1
    req = 4'b0110; req_blinks = 16'h0030;
    g = 0;
    for (int c = 0; c < 50 && g == 0; c++) begin
      @(negedge clk);
      if (gnt != 4'h0) g = 1;
    end
    chk("t5_gnt1", 32'(gnt), 32'b0010);
    @(negedge clk);
    chk("t5_led_on", 32'(led), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_led_off", 32'(led), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_nodone", 32'(done), 32'd0);
    @(negedge clk);
    chk("t5_gnt2", 32'(gnt), 32'b0100);
    chk("t5_nodone2", 32'(done), 32'd0);
    req = 4'h0;
    g = 0;
    for (int c = 0; c < 100 && g == 0; c++) begin
      @(negedge clk);
      if (done != 4'h0) g = 1;
    end
    chk("t5_done2", 32'(done), 32'b0100);

    // reset during GAP of a zero-blink sequence
    req = 4'b0010; req_blinks = 16'h0000;
    g = 0;
    for (int c = 0; c < 50 && g == 0; c++) begin
      @(negedge clk);
      if (gnt != 4'h0) g = 1;
    end
    chk("t6_gnt1", 32'(gnt), 32'b0010);
    req = 4'h0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_out", 32'({led, gnt, done, busy}), 32'd0);
    rst_n = 1'b1; req = 4'hF;
    @(negedge clk);
    chk("t6_done_gone", 32'(done), 32'd0);
    chk("t6_gnt0", 32'(gnt), 32'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
